riscv_wb_arbiter: RTL and testbench
===================================

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req0_ready  input / output  1 each  ALU writeback handshake.
REQ-006 req0_addr / req0_data  input  ADDR_WIDTH / DATA_WIDTH  ALU destination register and value.
REQ-007 req1_valid / req1_ready  input / output  1 each  load/store writeback handshake.
REQ-008 req1_addr / req1_data  input  ADDR_WIDTH / DATA_WIDTH  load/store destination register and value.
REQ-009 wb_hold  input  1  when high, blocks all grants.
REQ-010 wr_en / wr_addr / wr_data  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port.
REQ-011 rd_addrA / rd_addrB  input  ADDR_WIDTH each  register-file read addresses being decoded.
REQ-012 haz_a / haz_b  output  1 each  pending-write hazard on read port A / B.
REQ-013 stall_cnt  output  16  count of cycles in which a request was valid but not granted.

Function
REQ-014 A transfer on port i SHALL occur in a cycle where reqi_valid and reqi_ready are both 1.
REQ-015 reqi_ready SHALL be combinational: 1 only when port i is granted this cycle.
REQ-016 At most one port SHALL be granted per cycle.
REQ-017 With wb_hold=0 and exactly one port valid, that port SHALL be granted.
REQ-018 With wb_hold=0 and both ports valid, the port not recorded in last_grant SHALL be granted (round-robin).
REQ-019 last_grant SHALL update to the granted port on every transfer, and SHALL hold when no transfer occurs.
REQ-020 With wb_hold=1, both readies SHALL be 0, and last_grant SHALL hold.
REQ-021 A transfer with addr!=0 SHALL produce wr_en=1, with the registered wr_addr/wr_data of that request, in the following cycle only (latency 1).
REQ-022 A transfer with addr==0 SHALL complete the handshake and update last_grant, but SHALL leave wr_en=0 in the following cycle.
REQ-023 wr_en SHALL be 0 in any cycle not preceded by a qualifying transfer.
REQ-024 wr_addr/wr_data SHALL hold their last values when wr_en=0.
REQ-025 haz_a SHALL be 1 when rd_addrA!=0 and rd_addrA matches any of the following (combinational):
- wr_addr while wr_en=1;
- req0_addr while req0_valid=1;
- req1_addr while req1_valid=1.
REQ-026 haz_b SHALL follow the same rule as REQ-025 using rd_addrB.
REQ-027 stall_cnt SHALL increment by 1 in each cycle where (req0_valid and not req0_ready) or (req1_valid and not req1_ready), and SHALL saturate at 0xFFFF.
REQ-028 When both ports target the same register in the same cycle, they SHALL be written in grant order on consecutive cycles, so the second-granted value persists.
REQ-029 The arbiter SHALL not require valid to be held after a transfer; a requester that deasserts valid before being granted simply has no transfer.

Reset
REQ-030 While nrst=0, the following SHALL be forced immediately, independent of clk:
- wr_en=0, wr_addr=0, wr_data=0;
- last_grant=port 1, so port 0 wins the first tie;
- stall_cnt=0.
REQ-031 While nrst=0, req0_ready and req1_ready SHALL be 0.
REQ-032 A transfer accepted in the cycle reset asserts SHALL be discarded, with no wr_en after reset release.
REQ-033 The first grant SHALL be possible on the first rising edge with nrst=1.

Verification
REQ-034 Scenario: after reset, req0 and req1 valid in the same cycle (addr 5, data 0x11; addr 6, data 0x22) -> req0_ready=1 first; next cycle wr_en=1, wr_addr=5, wr_data=0x11; then wr_addr=6, wr_data=0x22; stall_cnt=1.
REQ-035 Scenario: both ports continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1; stall_cnt=6.
REQ-036 Scenario: req1 addr=0, data=0xDEAD, alone -> req1_ready=1; wr_en stays 0; next tie is granted to port 0.
REQ-037 Scenario: wb_hold=1 for 3 cycles with req0 valid (addr 7) -> ready=0 throughout; stall_cnt=3; haz_a=1 when rd_addrA=7; with rd_addrA=0, haz_a=0.
REQ-038 Scenario: both ports write addr 9 (0xAA on port 0, 0xBB on port 1) in one cycle -> two consecutive wr_en pulses, with 0xBB last.
REQ-039 Scenario: nrst pulsed low mid-transfer, asynchronously between clock edges -> wr_en drops to 0 at once; stall_cnt=0; no write issued after release.

Source files
------------

// File: rtl/riscv_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_arbiter_if
//  Purpose  : Bundles the writeback arbiter's bus-side signals: two requester
//             handshakes (ALU on port 0, load/store on port 1), the global
//             hold, the register-file write port, the hazard lookup and the
//             stall counter.
//  Modports : slave  - the arbiter (receives requests, drives the write port)
//             master - the surrounding pipeline / testbench
//  Revision : 1.0  initial release
// ============================================================================
interface riscv_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  // Port 0: ALU writeback
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  // Port 1: load/store writeback
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  // Global hold
  logic                  wb_hold;
  // Register-file write port
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  // Hazard lookup
  logic [ADDR_WIDTH-1:0] rd_addrA;
  logic [ADDR_WIDTH-1:0] rd_addrB;
  logic                  haz_a;
  logic                  haz_b;
  // Statistics
  logic [15:0]           stall_cnt;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  wb_hold,
    output wr_en, wr_addr, wr_data,
    input  rd_addrA, rd_addrB,
    output haz_a, haz_b,
    output stall_cnt
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output wb_hold,
    input  wr_en, wr_addr, wr_data,
    output rd_addrA, rd_addrB,
    input  haz_a, haz_b,
    input  stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single register-file
//             write port. Grants are combinational (ready in the same cycle as
//             valid); the winning request is written one cycle later. Writes
//             to register 0 complete the handshake but are dropped. Also
//             reports read-after-write hazards for two read ports and counts
//             cycles in which some requester was left waiting.
//  Ports    : clk  - clock, rising edge
//             nrst - asynchronous active-low reset
//             bus  - riscv_wb_arbiter_if.slave (requests, write port,
//                    hazard lookup, stall counter)
//  Revision : 1.0  initial release
// ============================================================================
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  wire                 clk,
  input  wire                 nrst,
  riscv_wb_arbiter_if.slave   bus
);

  localparam logic c_PORT0 = 1'b0;
  localparam logic c_PORT1 = 1'b1;
  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  logic                  r_last_grant;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [15:0]           r_stall_cnt;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_stall;

  // Port 0 wins when alone or when port 1 was the last one served; port 1
  // is the mirror image. nrst gates both so nothing is accepted in reset.
  assign w_grant0 = nrst && !bus.wb_hold && bus.req0_valid &&
                    (!bus.req1_valid || (r_last_grant == c_PORT1));
  assign w_grant1 = nrst && !bus.wb_hold && bus.req1_valid &&
                    (!bus.req0_valid || (r_last_grant == c_PORT0));

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  assign w_stall = (bus.req0_valid && !w_grant0) ||
                   (bus.req1_valid && !w_grant1);

  // A read address hits if a write to it is in flight in any stage: about
  // to be written (wr_en) or still waiting at either requester.
  function automatic logic f_hazard(input logic [ADDR_WIDTH-1:0] rd);
    f_hazard = (rd != '0) &&
               ((r_wr_en        && (r_wr_addr     == rd)) ||
                (bus.req0_valid && (bus.req0_addr == rd)) ||
                (bus.req1_valid && (bus.req1_addr == rd)));
  endfunction

  assign bus.haz_a = f_hazard(bus.rd_addrA);
  assign bus.haz_b = f_hazard(bus.rd_addrB);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_grant <= c_PORT1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_grant0) begin
        r_last_grant <= c_PORT0;
        // Register 0 is hard-wired: handshake completes, write is dropped.
        if (bus.req0_addr != '0) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= bus.req0_addr;
          r_wr_data <= bus.req0_data;
        end
      end else if (w_grant1) begin
        r_last_grant <= c_PORT1;
        if (bus.req1_addr != '0) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= bus.req1_addr;
          r_wr_data <= bus.req1_data;
        end
      end

      if (w_stall && (r_stall_cnt != c_STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_wb_arbiter
//  Purpose  : Self-checking bench for riscv_wb_arbiter. A table of per-cycle
//             vectors with hand-computed expectations walks through
//             tie-breaking, round-robin, register-0 writes, hold, same-target
//             writes and hazards; hand-written sequences cover reset
//             behaviour and stall-counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NV = 20;

  logic clk;
  logic nrst;

  riscv_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  riscv_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          hold;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          r0;
    logic          r1;
    logic          ha;
    logic          hb;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [15:0]   st;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic hold, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
    input logic r0, input logic r1, input logic ha, input logic hb,
    input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
    input logic [15:0] st);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.hold = hold; v.ra = ra; v.rb = rb;
    v.r0 = r0; v.r1 = r1; v.ha = ha; v.hb = hb;
    v.we = we; v.wa = wa; v.wd = wd; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0_valid = v.v0; bus.req0_addr = v.a0; bus.req0_data = v.d0;
    bus.req1_valid = v.v1; bus.req1_addr = v.a1; bus.req1_data = v.d1;
    bus.wb_hold    = v.hold;
    bus.rd_addrA   = v.ra; bus.rd_addrB = v.rb;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
  endtask

  initial begin
    //           v0 a0 d0        v1 a1 d1        h ra rb  r0 r1 ha hb  we wa wd        st
    // Tie after reset: port 0 first, then port 1 alone
    vecs[0]  = mk(1, 5, 32'h11,   1, 6, 32'h22,   0, 5, 6, 1, 0, 1, 1, 1, 5, 32'h11,   16'd1);
    vecs[1]  = mk(0, 0, 0,        1, 6, 32'h22,   0, 5, 3, 0, 1, 1, 0, 1, 6, 32'h22,   16'd1);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,        0, 6, 0, 0, 0, 1, 0, 0, 6, 32'h22,   16'd1);
    // Both continuously valid for 6 cycles: 0,1,0,1,0,1
    vecs[3]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h100,  16'd2);
    vecs[4]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h200,  16'd3);
    vecs[5]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h100,  16'd4);
    vecs[6]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h200,  16'd5);
    vecs[7]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h100,  16'd6);
    vecs[8]  = mk(1, 1, 32'h100,  1, 2, 32'h200,  0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h200,  16'd7);
    // Port 0 alone, then port 1 writes r0 (dropped), then tie goes to port 0
    vecs[9]  = mk(1, 8, 32'h88,   0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 1, 8, 32'h88,   16'd7);
    vecs[10] = mk(0, 0, 0,        1, 0, 32'hDEAD, 0, 8, 0, 0, 1, 1, 0, 0, 8, 32'h88,   16'd7);
    vecs[11] = mk(1, 3, 32'h33,   1, 4, 32'h44,   0, 4, 3, 1, 0, 1, 1, 1, 3, 32'h33,   16'd8);
    // Hold for 3 cycles with port 0 waiting on r7, then release
    vecs[12] = mk(1, 7, 32'h77,   0, 0, 0,        1, 7, 0, 0, 0, 1, 0, 0, 3, 32'h33,   16'd9);
    vecs[13] = mk(1, 7, 32'h77,   0, 0, 0,        1, 0, 3, 0, 0, 0, 0, 0, 3, 32'h33,   16'd10);
    vecs[14] = mk(1, 7, 32'h77,   0, 0, 0,        1, 7, 0, 0, 0, 1, 0, 0, 3, 32'h33,   16'd11);
    vecs[15] = mk(1, 7, 32'h77,   0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 1, 7, 32'h77,   16'd11);
    // Set last_grant to port 1, then both write r9: 0xAA then 0xBB
    vecs[16] = mk(0, 0, 0,        1, 10, 32'h1010, 0, 7, 0, 0, 1, 1, 0, 1, 10, 32'h1010, 16'd11);
    vecs[17] = mk(1, 9, 32'hAA,   1, 9, 32'hBB,   0, 9, 10, 1, 0, 1, 1, 1, 9, 32'hAA,   16'd12);
    vecs[18] = mk(0, 0, 0,        1, 9, 32'hBB,   0, 9, 0, 0, 1, 1, 0, 1, 9, 32'hBB,   16'd12);
    vecs[19] = mk(0, 0, 0,        0, 0, 0,        0, 9, 9, 0, 0, 1, 1, 0, 9, 32'hBB,   16'd12);

    // ---------------- Reset state (request present during reset) --------
    nrst = 1'b0;
    idle();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h55;
    #12;
    check("reset rdy0",    {31'd0, bus.req0_ready}, 32'd0);
    check("reset wr_en",   {31'd0, bus.wr_en},      32'd0);
    check("reset wr_addr", {27'd0, bus.wr_addr},    32'd0);
    check("reset wr_data", bus.wr_data,             32'd0);
    check("reset stall",   {16'd0, bus.stall_cnt},  32'd0);
    idle();
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    check("post-reset wr_en", {31'd0, bus.wr_en}, 32'd0);

    // ---------------- Table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d rdy0", i),  {31'd0, bus.req0_ready}, {31'd0, vecs[i].r0});
      check($sformatf("v%0d rdy1", i),  {31'd0, bus.req1_ready}, {31'd0, vecs[i].r1});
      check($sformatf("v%0d haz_a", i), {31'd0, bus.haz_a},      {31'd0, vecs[i].ha});
      check($sformatf("v%0d haz_b", i), {31'd0, bus.haz_b},      {31'd0, vecs[i].hb});
      @(posedge clk); #1;
      check($sformatf("v%0d wr_en", i),   {31'd0, bus.wr_en},     {31'd0, vecs[i].we});
      check($sformatf("v%0d wr_addr", i), {27'd0, bus.wr_addr},   {27'd0, vecs[i].wa});
      check($sformatf("v%0d wr_data", i), bus.wr_data,            vecs[i].wd);
      check($sformatf("v%0d stall", i),   {16'd0, bus.stall_cnt}, {16'd0, vecs[i].st});
    end

    // ---------------- Asynchronous reset mid-transfer ----------------
    idle();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd12; bus.req0_data = 32'hC;
    @(posedge clk); #1;
    check("pre-arst wr_en",   {31'd0, bus.wr_en},   32'd1);
    check("pre-arst wr_addr", {27'd0, bus.wr_addr}, 32'd12);
    // A second request is being accepted when reset hits between edges
    bus.req0_addr = 5'd13; bus.req0_data = 32'hD;
    #1;
    check("pre-arst rdy0", {31'd0, bus.req0_ready}, 32'd1);
    #1 nrst = 1'b0;
    #1;
    check("arst wr_en",   {31'd0, bus.wr_en},      32'd0);
    check("arst wr_addr", {27'd0, bus.wr_addr},    32'd0);
    check("arst wr_data", bus.wr_data,             32'd0);
    check("arst stall",   {16'd0, bus.stall_cnt},  32'd0);
    check("arst rdy0",    {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    check("in-reset wr_en", {31'd0, bus.wr_en}, 32'd0);
    // Release mid-cycle with a new request; first edge after release grants
    bus.req0_addr = 5'd14; bus.req0_data = 32'hE;
    #2 nrst = 1'b1;
    @(negedge clk);
    check("release rdy0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    check("release wr_en",   {31'd0, bus.wr_en},     32'd1);
    check("release wr_addr", {27'd0, bus.wr_addr},   32'd14);
    check("release wr_data", bus.wr_data,            32'hE);
    check("release stall",   {16'd0, bus.stall_cnt}, 32'd0);

    // ---------------- Stall counter saturation ----------------
    bus.wb_hold = 1'b1;
    bus.req0_addr = 5'd15;
    repeat (65534) @(posedge clk);
    #1;
    check("stall near max", {16'd0, bus.stall_cnt}, 32'hFFFE);
    check("hold wr_en",     {31'd0, bus.wr_en},     32'd0);
    @(posedge clk); #1;
    check("stall at max",   {16'd0, bus.stall_cnt}, 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("stall saturated", {16'd0, bus.stall_cnt}, 32'hFFFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
